nes_pad_reader: RTL

//   Initiator side of the NES-style gamepad serial link feeding the Enjimneering game core.
//   - On each poll request, drives latch/clock toward an external 4021-style pad and

---
 rtl/nes_pad_reader_pkg.sv | 23 ++
 rtl/nes_pad_reader_sync_ff.sv | 24 ++
 rtl/nes_pad_reader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nes_pad_reader_pkg.sv
// Shared definitions for the NES pad reader: FSM states and button bit positions
// (the button indices are also used by the game logic).
package nes_pad_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_GAP   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_LOW   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_reader_sync_ff.sv
// Multi-stage synchroniser for an asynchronous input. Resets to 1 so an idle
// pulled-up pad line never reads as a pressed button.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/nes_pad_reader.sv
// NES-style gamepad initiator: on poll, strobes latch, clocks out 8 active-low
// button bits from a 4021-style pad and presents them as an active-high byte.
module nes_pad_reader
    import nes_pad_reader_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = 150,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       poll,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       busy
);

    localparam int unsigned CW = $clog2(HALF_BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BIT_CYCLES - 1);

    logic          data_sync;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          second;
    logic [7:0]    shift;
    logic          cnt_last;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (nes_data),
        .q     (data_sync)
    );

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            second        <= 1'b0;
            shift         <= '0;
            nes_latch     <= 1'b0;
            nes_clk       <= 1'b0;
            buttons       <= '0;
            buttons_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            buttons_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (poll) begin
                        state     <= ST_LATCH;
                        nes_latch <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        second    <= 1'b0;
                    end
                end
                // Latch spans two full passes of the unit counter.
                ST_LATCH: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (second) begin
                            state     <= ST_GAP;
                            nes_latch <= 1'b0;
                        end else begin
                            second <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_last) begin
                        cnt      <= '0;
                        shift[0] <= data_sync;
                        idx      <= 3'd1;
                        state    <= ST_HIGH;
                        nes_clk  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        nes_clk <= 1'b0;
                        state   <= ST_LOW;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // The final bit is merged straight into buttons so the byte updates atomically.
                ST_LOW: begin
                    if (cnt_last) begin
                        cnt        <= '0;
                        shift[idx] <= data_sync;
                        if (idx == 3'd7) begin
                            state         <= ST_DONE;
                            buttons       <= ~{data_sync, shift[6:0]};
                            buttons_valid <= 1'b1;
                        end else begin
                            idx     <= idx + 3'd1;
                            state   <= ST_HIGH;
                            nes_clk <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
